// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD unit: FSM encoding, shift-counter width
// function and the step-counter width.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CYC_W = 16;

    // Enough bits to count every possible common factor of two, 0..W.
    function automatic int unsigned kw_of(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/gcd_binary_step.sv
// One combinational step of Stein's algorithm: reduces (a, b, k) and flags
// termination together with the rescaled result.
module gcd_binary_step
    import gcd_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = kw_of(W)
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  a_nxt,
    output logic [W-1:0]  b_nxt,
    output logic [KW-1:0] k_nxt,
    output logic          done,
    output logic [W-1:0]  res
);

    logic [W-1:0] diff_ab;
    logic [W-1:0] diff_ba;

    // Only the branch whose compare holds is used, so neither difference wraps.
    assign diff_ab = W'(a - b);
    assign diff_ba = W'(b - a);

    always_comb begin
        a_nxt = a;
        b_nxt = b;
        k_nxt = k;
        done  = 1'b0;
        res   = '0;
        if (a == '0) begin
            done = 1'b1;
            res  = W'(b << k);
        end else if (b == '0) begin
            done = 1'b1;
            res  = W'(a << k);
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + KW'(1);
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a >= b) begin
            a_nxt = diff_ab >> 1;
        end else begin
            b_nxt = diff_ba >> 1;
        end
    end

endmodule

// File: rtl/gcd_binary.sv
// Parametrised binary GCD unit with ready/valid operand and result channels.
// Optional macro GCD_CYCLE_COUNT_EN adds the result_cycles step-count output.
module gcd_binary
    import gcd_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = kw_of(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     operands_bits_A,
    input  logic [W-1:0]     operands_bits_B,
    input  logic             operands_val,
    output logic             operands_rdy,
    output logic [W-1:0]     result_bits_data,
    output logic             result_val,
    input  logic             result_rdy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0] result_cycles
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [KW-1:0]   k_q;
    logic [W-1:0]    res_q;
    logic [W-1:0]    a_d;
    logic [W-1:0]    b_d;
    logic [KW-1:0]   k_d;
    logic [W-1:0]    res_d;
    logic            rdy_q;
    logic            val_q;
    logic            load;
    logic            term;

    logic [W-1:0]    st_a;
    logic [W-1:0]    st_b;
    logic [KW-1:0]   st_k;
    logic            st_done;
    logic [W-1:0]    st_res;

    gcd_binary_step #(
        .W  (W),
        .KW (KW)
    ) u_step (
        .a     (a_q),
        .b     (b_q),
        .k     (k_q),
        .a_nxt (st_a),
        .b_nxt (st_b),
        .k_nxt (st_k),
        .done  (st_done),
        .res   (st_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        res_d     = res_q;
        load      = 1'b0;
        term      = 1'b0;
        case (state)
            IDLE: begin
                if (operands_val && rdy_q) begin
                    load      = 1'b1;
                    a_d       = operands_bits_A;
                    b_d       = operands_bits_B;
                    k_d       = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                a_d = st_a;
                b_d = st_b;
                k_d = st_k;
                if (st_done) begin
                    term      = 1'b1;
                    res_d     = st_res;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and handshake flags; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
            rdy_q <= 1'b0;
            val_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            k_q   <= k_d;
            res_q <= res_d;
            rdy_q <= (state_nxt == IDLE);
            val_q <= (state_nxt == DONE);
        end
    end

    assign operands_rdy     = rdy_q;
    assign result_val       = val_q;
    assign result_bits_data = res_q;

`ifdef GCD_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic [CYC_W-1:0] cyc_inc;
    logic [CYC_W-1:0] res_cyc_q;
    logic [CYC_W-1:0] res_cyc_d;

    // Saturating step counter; the terminating step itself is included.
    always_comb begin
        cyc_inc   = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
        cyc_d     = cyc_q;
        res_cyc_d = res_cyc_q;
        if (load) begin
            cyc_d = '0;
        end else if (state == CALC) begin
            cyc_d = cyc_inc;
        end
        if (term) begin
            res_cyc_d = cyc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q     <= '0;
            res_cyc_q <= '0;
        end else begin
            cyc_q     <= cyc_d;
            res_cyc_q <= res_cyc_d;
        end
    end

    assign result_cycles = res_cyc_q;
`endif

endmodule

// File: tb/tb_gcd_binary.sv
// Directed bench for gcd_binary at W=16 and W=32 with hand-computed results
// and step counts; honours GCD_CYCLE_COUNT_EN when defined.
module tb_gcd_binary;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] d16;
    logic        val16;
    logic        rdy16;
    logic        rv16;
    logic        rr16;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] d32;
    logic        val32;
    logic        rdy32;
    logic        rv32;
    logic        rr32;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cyc16;
    logic [15:0] cyc32;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gcd_binary #(.W(16)) dut16 (
        .clk              (clk),
        .reset            (reset),
        .operands_bits_A  (a16),
        .operands_bits_B  (b16),
        .operands_val     (val16),
        .operands_rdy     (rdy16),
        .result_bits_data (d16),
        .result_val       (rv16),
        .result_rdy       (rr16)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .result_cycles    (cyc16)
`endif
    );

    gcd_binary #(.W(32)) dut32 (
        .clk              (clk),
        .reset            (reset),
        .operands_bits_A  (a32),
        .operands_bits_B  (b32),
        .operands_val     (val32),
        .operands_rdy     (rdy32),
        .result_bits_data (d32),
        .result_val       (rv32),
        .result_rdy       (rr32)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .result_cycles    (cyc32)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=16 transaction; hold > 0 stalls the consumer that many cycles.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input int n_exp, input int hold, input string tag);
        int n;
        logic [15:0] d_seen;
        for (int i = 0; i < 40 && rdy16 !== 1'b1; i++) tick();
        check({tag, "_rdy"}, 64'(rdy16), 64'd1);
        a16   = a;
        b16   = b;
        val16 = 1'b1;
        tick();
        val16 = 1'b0;
        a16   = 16'hFFFF;
        b16   = 16'h0003;
        check({tag, "_busy"}, 64'(rdy16), 64'd0);
        n = 0;
        while (rv16 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_val"}, 64'(rv16), 64'd1);
        check({tag, "_data"}, 64'(d16), 64'(r));
        check({tag, "_steps"}, 64'(n), 64'(n_exp));
`ifdef GCD_CYCLE_COUNT_EN
        check({tag, "_cycles"}, 64'(cyc16), 64'(n_exp));
`endif
        d_seen = d16;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_val"}, 64'(rv16), 64'd1);
            check({tag, "_hold_data"}, 64'(d16), 64'(d_seen));
            check({tag, "_hold_rdy"}, 64'(rdy16), 64'd0);
        end
        rr16 = 1'b1;
        tick();
        rr16 = 1'b0;
        check({tag, "_post_val"}, 64'(rv16), 64'd0);
        check({tag, "_post_rdy"}, 64'(rdy16), 64'd1);
    endtask

    initial begin
        int n;
        bit saw_val;
        reset = 1'b1;
        a16 = '0; b16 = '0; val16 = 1'b0; rr16 = 1'b0;
        a32 = '0; b32 = '0; val32 = 1'b0; rr32 = 1'b0;
        repeat (5) tick();
        check("in_reset_rdy", 64'(rdy16), 64'd0);
        check("in_reset_val", 64'(rv16), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_rdy16", 64'(rdy16), 64'd1);
        check("rst_val16", 64'(rv16), 64'd0);
        check("rst_data16", 64'(d16), 64'd0);
        check("rst_rdy32", 64'(rdy32), 64'd1);
        check("rst_data32", 64'(d32), 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check("rst_cycles16", 64'(cyc16), 64'd0);
`endif

        op16(16'd27,    16'd15,  16'd3,  6,  0, "g27_15");
        op16(16'd21,    16'd49,  16'd7,  5,  0, "g21_49");
        op16(16'd25,    16'd30,  16'd5,  5,  0, "g25_30");
        op16(16'd19,    16'd27,  16'd1,  9,  0, "g19_27");
        op16(16'd250,   16'd190, 16'd10, 9,  0, "g250_190");
        op16(16'd5,     16'd250, 16'd5,  7,  0, "g5_250");
        op16(16'd40,    16'd40,  16'd40, 5,  0, "g40_40");
        op16(16'd0,     16'd0,   16'd0,  1,  0, "g0_0");
        op16(16'd8,     16'd0,   16'd8,  1,  0, "g8_0");
        op16(16'd0,     16'd9,   16'd9,  1,  0, "g0_9");
        op16(16'd65535, 16'd1,   16'd1,  17, 0, "g65535_1");
        op16(16'd27,    16'd15,  16'd3,  6,  10, "hold");
        op16(16'd21,    16'd49,  16'd7,  5,  0, "after_hold");

        // W=32 instance
        a32 = 32'd12;
        b32 = 32'd18;
        val32 = 1'b1;
        tick();
        val32 = 1'b0;
        n = 0;
        while (rv32 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("w32_val", 64'(rv32), 64'd1);
        check("w32_data", 64'(d32), 64'd6);
        check("w32_steps", 64'(n), 64'd5);
`ifdef GCD_CYCLE_COUNT_EN
        check("w32_cycles", 64'(cyc32), 64'd5);
`endif
        rr32 = 1'b1;
        tick();
        rr32 = 1'b0;
        check("w32_post_rdy", 64'(rdy32), 64'd1);

        // Abort a long computation with reset
        a16 = 16'd65535;
        b16 = 16'd1;
        val16 = 1'b1;
        tick();
        val16 = 1'b0;
        repeat (5) tick();
        check("abort_busy", 64'(rdy16), 64'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_rdy", 64'(rdy16), 64'd1);
        check("abort_val", 64'(rv16), 64'd0);
        saw_val = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rv16 === 1'b1) saw_val = 1'b1;
        end
        check("abort_no_result", 64'(saw_val), 64'd0);
        op16(16'd21, 16'd49, 16'd7, 5, 0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_binary.md
# gcd_binary

Parametrised greatest-common-divisor unit, the next generation of the 16-bit `gcd` block. It computes GCD with the binary (Stein's) algorithm. Both operands share one ready/valid input channel. The result is returned on a ready/valid output channel, and the operand width is configurable. It keeps the port naming of `gcd`, so benches and surrounding designs switch over with only a parameter change.

## Interface
- `W`, default 16, operand and result width in bits; legal values are ≥ 2.
- `KW`, default `$clog2(W+1)`, width of the common-power-of-two shift counter; it is derived and must not be overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `operands_bits_A`  in  W  operand A.
- `operands_bits_B`  in  W  operand B.
- `operands_val`  in  1  operands valid.
- `operands_rdy`  out  1  unit can accept operands.
- `result_bits_data`  out  W  gcd(A, B).
- `result_val`  out  1  result valid.
- `result_rdy`  in  1  consumer accepts the result.
- `result_cycles`  out  16  number of CALC steps used for this result; present only with `GCD_CYCLE_COUNT_EN`.

## Operation
- States: IDLE, CALC, DONE. Internal registers: `a`, `b` (W bits each), `k` (KW bits), `res` (W bits).
- IDLE:
  - `operands_rdy` = 1.
  - When `operands_val` is high, load `a` and `b` from the operands, set `k` = 0, and go to CALC.
- CALC performs one step per cycle, with conditions evaluated in this order:
  1. `a`==0: `res` ← `b<<k`, go to DONE.
  2. `b`==0: `res` ← `a<<k`, go to DONE.
  3. Both even: `a`>>=1, `b`>>=1, `k`++.
  4. `a` even: `a`>>=1.
  5. `b` even: `b`>>=1.
  6. Both odd: if `a`≥`b` then `a` ← `(a−b)>>1`, else `b` ← `(b−a)>>1`.
- Arithmetic:
  - The subtraction is unsigned, W bits wide, and never underflows because of the compare.
  - `b<<k` and `a<<k` are truncated to W bits. No overflow is possible because the result is ≤ min(A, B), except when one operand is 0.
- Zero operands: gcd(0,0)=0 and gcd(x,0)=gcd(0,x)=x.
- DONE:
  - `result_val` = 1 and `result_bits_data` = `res`.
  - The result is held stable until `result_rdy` is high. On that edge the unit goes to IDLE.
- `operands_rdy` is high only in IDLE, so there is exactly one idle cycle between a result handshake and the next operand acceptance.
- Operand inputs are ignored outside IDLE. A change on them mid-computation has no effect.
- Reset mid-operation abandons the computation and forces IDLE on the next edge.

## Timing
- Operands are accepted on the edge where `operands_val` && `operands_rdy`.
- Each following edge performs one CALC step. The terminating step (rule 1 or 2) moves the unit to DONE.
- `result_val` rises in the cycle after the terminating step.
- Latency is N cycles from acceptance to `result_val`, where N is the number of CALC steps. N ≤ 2W+1.
- Reset values: `operands_rdy`=0 during reset and 1 in the first cycle after; `result_val`=0; `result_bits_data`=0; `result_cycles`=0. All internal registers are cleared to 0.
- Outputs are registered or decoded from state only. There is no combinational path from `operands_val` or `result_rdy` to any output.

## Configuration
- `GCD_CYCLE_COUNT_EN` defined:
  - A 16-bit step counter clears on operand acceptance and increments on every CALC edge, saturating at 0xFFFF.
  - Its value is latched into `result_cycles` on the terminating step.
  - `result_cycles` is held with the result and reset to 0.
- `GCD_CYCLE_COUNT_EN` undefined: the `result_cycles` port and counter do not exist. All other behaviour is identical.

## Structure
- `gcd_pkg` holds:
  - the state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the `KW` width function;
  - the 16-bit cycle-count width constant.
- Sub-module `gcd_binary_step` is purely combinational. It takes `a`, `b`, `k` and produces next `a`, `b`, `k`, a `done` flag and the shifted result. The FSM, handshake logic and registers stay in `gcd_binary`.

## Test plan
- Reset for 5 cycles, then release → `operands_rdy`=1, `result_val`=0, `result_bits_data`=0.
- W=16 vectors (27,15), (21,49), (25,30), (19,27), (250,190), (5,250) → results 3, 7, 5, 1, 10, 5, each checked at the `result_val` handshake.
- (40,40) → result 40 after 5 steps (`result_cycles`=5); (0,0) → 0 after 1 step; (8,0) → 8 after 1 step; (0,9) → 9 after 1 step.
- (65535,1) at W=16 → result 1 after 17 steps; repeat at W=32 with (12,18) → 6.
- Hold `result_rdy`=0 for 10 cycles after `result_val` → `result_val` and data stay stable and `operands_rdy` stays 0. Raise `result_rdy` → IDLE on the next edge, and a new operand is accepted one cycle later.
- Assert `reset` during CALC of (65535,1) → `operands_rdy`=1 the cycle after release and no `result_val`. Then (21,49) → 7.
